// File: rtl/memory_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_port_arbiter_if
// Brief    : Fetch, data and external memory bus signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_port_arbiter_if;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        fetchAck;
  logic        fetchError;
  logic [31:0] fetchDataRead;

  logic        dataRequest;
  logic [31:0] dataAddress;
  logic [3:0]  dataByteSelect;
  logic        dataWriteEnable;
  logic [31:0] dataWriteData;
  logic        dataAck;
  logic        dataError;
  logic [31:0] dataDataRead;

  logic        mem_enable;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteSelect;
  logic        mem_writeEnable;
  logic [31:0] mem_dataWrite;
  logic [31:0] mem_dataRead;
  logic        mem_busy;

  logic        arbiterBusy;
  logic        currentOwner;

  // Arbiter side
  modport slave (
    input  fetchRequest, fetchAddress,
    input  dataRequest, dataAddress, dataByteSelect, dataWriteEnable, dataWriteData,
    input  mem_dataRead, mem_busy,
    output fetchAck, fetchError, fetchDataRead,
    output dataAck, dataError, dataDataRead,
    output mem_enable, mem_address, mem_byteSelect, mem_writeEnable, mem_dataWrite,
    output arbiterBusy, currentOwner
  );

  // Requester / memory side
  modport master (
    output fetchRequest, fetchAddress,
    output dataRequest, dataAddress, dataByteSelect, dataWriteEnable, dataWriteData,
    output mem_dataRead, mem_busy,
    input  fetchAck, fetchError, fetchDataRead,
    input  dataAck, dataError, dataDataRead,
    input  mem_enable, mem_address, mem_byteSelect, mem_writeEnable, mem_dataWrite,
    input  arbiterBusy, currentOwner
  );
endinterface
`default_nettype wire

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_port_arbiter
// Brief    : Shares one memory bus between fetch and data requesters.
// Revision : 1.0 - initial release
// ============================================================================
module memory_port_arbiter #(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int MAX_DATA_STREAK = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  memory_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] C_MAX_STREAK   = 4'(MAX_DATA_STREAK);
  localparam logic [3:0] C_STREAK_SAT   = 4'd15;

  state_t      r_state;
  logic        r_owner;
  logic [3:0]  r_streak;
  logic [7:0]  r_timeout;
  logic        r_fetchAck;
  logic        r_fetchError;
  logic [31:0] r_fetchDataRead;
  logic        r_dataAck;
  logic        r_dataError;
  logic [31:0] r_dataDataRead;
  logic        r_busy;

  logic w_grantData;
  logic w_grantFetch;
  logic w_access;

  // Data wins unless fetch has been starved for a full streak.
  assign w_grantData  = bus.dataRequest && (!bus.fetchRequest || (r_streak < C_MAX_STREAK));
  assign w_grantFetch = !w_grantData && bus.fetchRequest;
  assign w_access     = (r_state == ACCESS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_owner         <= 1'b0;
      r_streak        <= 4'd0;
      r_timeout       <= 8'd0;
      r_fetchAck      <= 1'b0;
      r_fetchError    <= 1'b0;
      r_fetchDataRead <= 32'd0;
      r_dataAck       <= 1'b0;
      r_dataError     <= 1'b0;
      r_dataDataRead  <= 32'd0;
      r_busy          <= 1'b0;
    end else begin
      r_fetchAck   <= 1'b0;
      r_fetchError <= 1'b0;
      r_dataAck    <= 1'b0;
      r_dataError  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timeout <= 8'd0;
          if (w_grantData) begin
            r_owner <= 1'b1;
            r_state <= ACCESS;
            r_busy  <= 1'b1;
            if (bus.fetchRequest) begin
              r_streak <= (r_streak == C_STREAK_SAT) ? C_STREAK_SAT : r_streak + 4'd1;
            end else begin
              r_streak <= 4'd0;
            end
          end else if (w_grantFetch) begin
            r_owner  <= 1'b0;
            r_state  <= ACCESS;
            r_busy   <= 1'b1;
            r_streak <= 4'd0;
          end
        end
        ACCESS: begin
          if (!bus.mem_busy) begin
            r_state <= RESPOND;
            if (r_owner) begin
              r_dataAck      <= 1'b1;
              r_dataDataRead <= bus.dataWriteEnable ? 32'd0 : bus.mem_dataRead;
            end else begin
              r_fetchAck      <= 1'b1;
              r_fetchDataRead <= bus.mem_dataRead;
            end
          end else if (r_timeout == C_TIMEOUT_LAST) begin
            // This is the last permitted busy cycle: give up with an error.
            r_state <= RESPOND;
            if (r_owner) begin
              r_dataAck      <= 1'b1;
              r_dataError    <= 1'b1;
              r_dataDataRead <= 32'd0;
            end else begin
              r_fetchAck      <= 1'b1;
              r_fetchError    <= 1'b1;
              r_fetchDataRead <= 32'd0;
            end
          end else begin
            r_timeout <= r_timeout + 8'd1;
          end
        end
        RESPOND: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_enable      = w_access;
  assign bus.mem_address     = !w_access ? 32'd0 : (r_owner ? bus.dataAddress : bus.fetchAddress);
  assign bus.mem_byteSelect  = !w_access ? 4'd0  : (r_owner ? bus.dataByteSelect : 4'b1111);
  assign bus.mem_writeEnable = w_access && r_owner && bus.dataWriteEnable;
  assign bus.mem_dataWrite   = (w_access && r_owner) ? bus.dataWriteData : 32'd0;

  assign bus.fetchAck      = r_fetchAck;
  assign bus.fetchError    = r_fetchError;
  assign bus.fetchDataRead = r_fetchDataRead;
  assign bus.dataAck       = r_dataAck;
  assign bus.dataError     = r_dataError;
  assign bus.dataDataRead  = r_dataDataRead;
  assign bus.arbiterBusy   = r_busy;
  assign bus.currentOwner  = r_owner;

endmodule
`default_nettype wire
